// File: rtl/flag_unit_if.sv
// Flag-unit bundle: ALU flag inputs, control-unit requests, and the flag/branch results.
interface flag_unit_if;
    logic       alu_c;
    logic       alu_z;
    logic       flg_c_ld;
    logic       flg_z_ld;
    logic       flg_c_set;
    logic       flg_c_clr;
    logic       i_set;
    logic       i_clr;
    logic       intr;
    logic       int_ack;
    logic       reti;
    logic       reti_ien;
    logic [2:0] br_cond;
    logic       c_flag;
    logic       z_flag;
    logic       cin;
    logic       i_flag;
    logic       int_req;
    logic       br_take;

    modport master (
        output alu_c, alu_z, flg_c_ld, flg_z_ld, flg_c_set, flg_c_clr,
        output i_set, i_clr, intr, int_ack, reti, reti_ien, br_cond,
        input  c_flag, z_flag, cin, i_flag, int_req, br_take
    );

    modport slave (
        input  alu_c, alu_z, flg_c_ld, flg_z_ld, flg_c_set, flg_c_clr,
        input  i_set, i_clr, intr, int_ack, reti, reti_ien, br_cond,
        output c_flag, z_flag, cin, i_flag, int_req, br_take
    );
endinterface

// File: rtl/flag_unit.sv
// Purpose: C/Z/I flag registers, interrupt shadow and pending latch, branch evaluation.
// Latency: flag updates visible one edge after the request; int_req/br_take combinational from registers.
// Backpressure: none, every request is accepted on the edge it is presented.
module flag_unit #(
    parameter bit INT_EDGE = 1'b1,
    parameter bit RESET_I  = 1'b0
) (
    input logic      clk,
    input logic      rst_n,
    flag_unit_if.slave fi
);

    logic c_q;
    logic z_q;
    logic sh_c_q;
    logic sh_z_q;
    logic i_q;
    logic pend_q;
    logic intr_q;
    logic ack;
    logic rise;

    // INT_ACK loses to RETI in every respect, including clearing the pending latch.
    assign ack  = fi.int_ack & ~fi.reti;
    assign rise = fi.intr & ~intr_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            c_q    <= 1'b0;
            z_q    <= 1'b0;
            sh_c_q <= 1'b0;
            sh_z_q <= 1'b0;
            i_q    <= RESET_I;
            pend_q <= 1'b0;
            intr_q <= 1'b0;
        end else begin
            intr_q <= fi.intr;

            if (INT_EDGE) begin
                if (rise)
                    pend_q <= 1'b1;
                else if (ack)
                    pend_q <= 1'b0;
            end else begin
                pend_q <= fi.intr & ~ack;
            end

            if (fi.reti) begin
                c_q <= sh_c_q;
                z_q <= sh_z_q;
                i_q <= fi.reti_ien;
            end else begin
                if (fi.flg_c_clr)
                    c_q <= 1'b0;
                else if (fi.flg_c_set)
                    c_q <= 1'b1;
                else if (fi.flg_c_ld)
                    c_q <= fi.alu_c;

                if (fi.flg_z_ld)
                    z_q <= fi.alu_z;

                if (ack) begin
                    sh_c_q <= c_q;
                    sh_z_q <= z_q;
                    i_q    <= 1'b0;
                end else if (fi.i_clr) begin
                    i_q <= 1'b0;
                end else if (fi.i_set) begin
                    i_q <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        fi.br_take = 1'b0;
        case (fi.br_cond)
            3'b000:  fi.br_take = 1'b1;
            3'b001:  fi.br_take = ~c_q;
            3'b010:  fi.br_take = c_q;
            3'b011:  fi.br_take = z_q;
            3'b100:  fi.br_take = ~z_q;
            default: fi.br_take = 1'b0;
        endcase
    end

    assign fi.c_flag  = c_q;
    assign fi.z_flag  = z_q;
    assign fi.cin     = c_q;
    assign fi.i_flag  = i_q;
    assign fi.int_req = pend_q & i_q;

endmodule

// File: tb/tb_flag_unit.sv
// Directed bench for flag_unit with INT_EDGE=1, RESET_I=0.
module tb_flag_unit;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    flag_unit_if fi ();

    flag_unit #(.INT_EDGE(1'b1), .RESET_I(1'b0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .fi    (fi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        fi.alu_c = 0; fi.alu_z = 0; fi.flg_c_ld = 0; fi.flg_z_ld = 0;
        fi.flg_c_set = 0; fi.flg_c_clr = 0; fi.i_set = 0; fi.i_clr = 0;
        fi.int_ack = 0; fi.reti = 0; fi.reti_ien = 0; fi.br_cond = 3'b000;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 0; fi.flg_c_set = 1; fi.intr = 1;
        tick();
        total++; if (fi.c_flag !== 1'b0) begin bad++; $display("FAIL reset_c got=%b want=0", fi.c_flag); end
        total++; if (fi.z_flag !== 1'b0) begin bad++; $display("FAIL reset_z got=%b want=0", fi.z_flag); end
        total++; if (fi.i_flag !== 1'b0) begin bad++; $display("FAIL reset_i got=%b want=0", fi.i_flag); end
        total++; if (fi.int_req !== 1'b0) begin bad++; $display("FAIL reset_intreq got=%b want=0", fi.int_req); end
        rst_n = 1; idle(); fi.intr = 0;
        tick();
    endtask

    task automatic test_load();
        fi.alu_c = 1; fi.alu_z = 0; fi.flg_c_ld = 1; fi.flg_z_ld = 1;
        tick();
        idle();
        total++; if (fi.c_flag !== 1'b1) begin bad++; $display("FAIL load_c got=%b want=1", fi.c_flag); end
        total++; if (fi.cin !== 1'b1) begin bad++; $display("FAIL load_cin got=%b want=1", fi.cin); end
        total++; if (fi.z_flag !== 1'b0) begin bad++; $display("FAIL load_z got=%b want=0", fi.z_flag); end
        fi.br_cond = 3'b010; #1;
        total++; if (fi.br_take !== 1'b1) begin bad++; $display("FAIL br_cs got=%b want=1", fi.br_take); end
        fi.br_cond = 3'b011; #1;
        total++; if (fi.br_take !== 1'b0) begin bad++; $display("FAIL br_eq got=%b want=0", fi.br_take); end
        fi.br_cond = 3'b111; #1;
        total++; if (fi.br_take !== 1'b0) begin bad++; $display("FAIL br_never got=%b want=0", fi.br_take); end
        fi.br_cond = 3'b001; #1;
        total++; if (fi.br_take !== 1'b0) begin bad++; $display("FAIL br_cc got=%b want=0", fi.br_take); end
        fi.br_cond = 3'b000; #1;
        total++; if (fi.br_take !== 1'b1) begin bad++; $display("FAIL br_always got=%b want=1", fi.br_take); end
        fi.alu_z = 1; fi.flg_z_ld = 1;
        tick();
        idle();
        fi.br_cond = 3'b011; #1;
        total++; if (fi.br_take !== 1'b1) begin bad++; $display("FAIL br_eq_z1 got=%b want=1", fi.br_take); end
        fi.br_cond = 3'b100; #1;
        total++; if (fi.br_take !== 1'b0) begin bad++; $display("FAIL br_ne_z1 got=%b want=0", fi.br_take); end
        fi.br_cond = 3'b101; #1;
        total++; if (fi.br_take !== 1'b0) begin bad++; $display("FAIL br_101 got=%b want=0", fi.br_take); end
    endtask

    task automatic test_c_priority();
        fi.flg_c_set = 1; fi.flg_c_clr = 1; fi.flg_c_ld = 1; fi.alu_c = 1;
        tick();
        idle();
        total++; if (fi.c_flag !== 1'b0) begin bad++; $display("FAIL cpri_clr got=%b want=0", fi.c_flag); end
        fi.flg_c_set = 1; fi.flg_c_ld = 1; fi.alu_c = 0;
        tick();
        idle();
        total++; if (fi.c_flag !== 1'b1) begin bad++; $display("FAIL cpri_set got=%b want=1", fi.c_flag); end
        fi.alu_c = 0;
        tick();
        total++; if (fi.c_flag !== 1'b1) begin bad++; $display("FAIL c_hold got=%b want=1", fi.c_flag); end
        fi.flg_c_ld = 1; fi.alu_c = 0;
        tick();
        idle();
        total++; if (fi.c_flag !== 1'b0) begin bad++; $display("FAIL c_ld0 got=%b want=0", fi.c_flag); end
    endtask

    task automatic test_intr();
        fi.i_set = 1;
        tick();
        idle();
        total++; if (fi.i_flag !== 1'b1) begin bad++; $display("FAIL sei_i got=%b want=1", fi.i_flag); end
        total++; if (fi.int_req !== 1'b0) begin bad++; $display("FAIL sei_noreq got=%b want=0", fi.int_req); end
        fi.intr = 1;
        tick();
        total++; if (fi.int_req !== 1'b1) begin bad++; $display("FAIL intr_edge got=%b want=1", fi.int_req); end
        tick();
        tick();
        fi.int_ack = 1;
        tick();
        idle();
        total++; if (fi.int_req !== 1'b0) begin bad++; $display("FAIL ack_clear got=%b want=0", fi.int_req); end
        total++; if (fi.i_flag !== 1'b0) begin bad++; $display("FAIL ack_i got=%b want=0", fi.i_flag); end
        fi.i_set = 1;
        tick();
        idle();
        total++; if (fi.int_req !== 1'b0) begin bad++; $display("FAIL level_once got=%b want=0", fi.int_req); end
        fi.intr = 0;
        tick();
        fi.intr = 1;
        tick();
        total++; if (fi.int_req !== 1'b1) begin bad++; $display("FAIL second_edge got=%b want=1", fi.int_req); end
        fi.i_clr = 1; fi.i_set = 1;
        tick();
        idle();
        total++; if (fi.int_req !== 1'b0) begin bad++; $display("FAIL cli_mask got=%b want=0", fi.int_req); end
        fi.i_set = 1;
        tick();
        idle();
        total++; if (fi.int_req !== 1'b1) begin bad++; $display("FAIL pend_held got=%b want=1", fi.int_req); end
        fi.int_ack = 1; fi.intr = 0;
        tick();
        idle();
    endtask

    task automatic test_int_ack();
        fi.flg_c_set = 1; fi.alu_z = 1; fi.flg_z_ld = 1;
        tick();
        idle();
        fi.int_ack = 1; fi.flg_c_clr = 1; fi.i_set = 1;
        tick();
        idle();
        total++; if (fi.c_flag !== 1'b0) begin bad++; $display("FAIL ack_c got=%b want=0", fi.c_flag); end
        total++; if (fi.z_flag !== 1'b1) begin bad++; $display("FAIL ack_z got=%b want=1", fi.z_flag); end
        total++; if (fi.i_flag !== 1'b0) begin bad++; $display("FAIL ack_i2 got=%b want=0", fi.i_flag); end
        total++; if (fi.int_req !== 1'b0) begin bad++; $display("FAIL ack_req got=%b want=0", fi.int_req); end
        fi.flg_z_ld = 1; fi.alu_z = 0;
        tick();
        idle();
        fi.reti = 1; fi.reti_ien = 1;
        tick();
        idle();
        total++; if (fi.c_flag !== 1'b1) begin bad++; $display("FAIL reti_c got=%b want=1", fi.c_flag); end
        total++; if (fi.z_flag !== 1'b1) begin bad++; $display("FAIL reti_z got=%b want=1", fi.z_flag); end
        total++; if (fi.i_flag !== 1'b1) begin bad++; $display("FAIL reti_i got=%b want=1", fi.i_flag); end
    endtask

    task automatic test_ack_edge();
        fi.intr = 0;
        tick();
        fi.intr = 1; fi.int_ack = 1;
        tick();
        idle();
        total++; if (fi.i_flag !== 1'b0) begin bad++; $display("FAIL ackedge_i got=%b want=0", fi.i_flag); end
        fi.i_set = 1;
        tick();
        idle();
        total++; if (fi.int_req !== 1'b1) begin bad++; $display("FAIL ackedge_pend got=%b want=1", fi.int_req); end
    endtask

    task automatic test_reti_ack();
        // shadow holds {1,1}; drive live flags to {0,0} first
        fi.flg_c_clr = 1; fi.flg_z_ld = 1; fi.alu_z = 0;
        tick();
        idle();
        fi.reti = 1; fi.int_ack = 1; fi.reti_ien = 0; fi.flg_c_set = 1; fi.i_set = 1;
        tick();
        idle();
        total++; if (fi.c_flag !== 1'b1) begin bad++; $display("FAIL retiack_c got=%b want=1", fi.c_flag); end
        total++; if (fi.z_flag !== 1'b1) begin bad++; $display("FAIL retiack_z got=%b want=1", fi.z_flag); end
        total++; if (fi.i_flag !== 1'b0) begin bad++; $display("FAIL retiack_i got=%b want=0", fi.i_flag); end
        fi.i_set = 1;
        tick();
        idle();
        total++; if (fi.int_req !== 1'b1) begin bad++; $display("FAIL retiack_pend got=%b want=1", fi.int_req); end
        fi.flg_c_clr = 1; fi.flg_z_ld = 1; fi.alu_z = 0;
        tick();
        idle();
        fi.reti = 1; fi.reti_ien = 1;
        tick();
        idle();
        total++; if (fi.c_flag !== 1'b1) begin bad++; $display("FAIL shadow_keep_c got=%b want=1", fi.c_flag); end
        total++; if (fi.z_flag !== 1'b1) begin bad++; $display("FAIL shadow_keep_z got=%b want=1", fi.z_flag); end
    endtask

    task automatic test_rst_mid();
        rst_n = 0; fi.flg_c_set = 1; fi.i_set = 1;
        tick();
        rst_n = 1; idle();
        total++; if (fi.c_flag !== 1'b0) begin bad++; $display("FAIL rstmid_c got=%b want=0", fi.c_flag); end
        total++; if (fi.z_flag !== 1'b0) begin bad++; $display("FAIL rstmid_z got=%b want=0", fi.z_flag); end
        total++; if (fi.i_flag !== 1'b0) begin bad++; $display("FAIL rstmid_i got=%b want=0", fi.i_flag); end
        fi.intr = 0; fi.i_set = 1;
        tick();
        idle();
        total++; if (fi.int_req !== 1'b0) begin bad++; $display("FAIL rstmid_pend got=%b want=0", fi.int_req); end
        fi.flg_c_set = 1; fi.flg_z_ld = 1; fi.alu_z = 1;
        tick();
        idle();
        fi.reti = 1; fi.reti_ien = 0;
        tick();
        idle();
        total++; if (fi.c_flag !== 1'b0) begin bad++; $display("FAIL rstmid_shc got=%b want=0", fi.c_flag); end
        total++; if (fi.z_flag !== 1'b0) begin bad++; $display("FAIL rstmid_shz got=%b want=0", fi.z_flag); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 0;
        fi.intr = 0;
        idle();
        test_reset();
        test_load();
        test_c_priority();
        test_intr();
        test_int_ack();
        test_ack_edge();
        test_reti_ack();
        test_rst_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/flag_unit.md
Name: flag_unit

Overview:
Receiving end of the ALU flag interface: registers the C and Z flags produced by the ALU and returns the carry flag as the ALU carry-in. Holds the interrupt-enable flag, the shadow flags for interrupt entry/exit, and an interrupt-pending latch. Evaluates branch conditions for the control unit. Sits between the ALU and the control-unit FSM in the CPU datapath.

Parameters:
INT_EDGE, 1, 1 = INTR is rising-edge detected into the pending latch; 0 = the pending latch follows the INTR level each cycle.
RESET_I, 0, reset value of I_FLAG.

Ports:
CLK  in  1  system clock, all state updates on rising edge
RST_N  in  1  synchronous reset, active-low
ALU_C  in  1  carry/borrow output from the ALU
ALU_Z  in  1  zero output from the ALU
FLG_C_LD  in  1  load C from ALU_C
FLG_Z_LD  in  1  load Z from ALU_Z
FLG_C_SET  in  1  force C = 1 (SEC)
FLG_C_CLR  in  1  force C = 0 (CLC)
I_SET  in  1  enable interrupts (SEI)
I_CLR  in  1  disable interrupts (CLI)
INTR  in  1  external interrupt request, synchronous to CLK
INT_ACK  in  1  control unit entering the interrupt cycle
RETI  in  1  return from interrupt
RETI_IEN  in  1  I value restored on RETI (1 = RETIE, 0 = RETID)
BR_COND  in  3  branch condition select
C_FLAG  out  1  registered carry flag
Z_FLAG  out  1  registered zero flag
CIN  out  1  carry-in to the ALU, equal to C_FLAG
I_FLAG  out  1  registered interrupt enable
INT_REQ  out  1  pending & I_FLAG, combinational from registers
BR_TAKE  out  1  branch decision, combinational from flags

Behaviour:
- Reset, on the edge where RST_N = 0: C_FLAG = 0, Z_FLAG = 0, shadow C = 0, shadow Z = 0, I_FLAG = RESET_I, pending = 0, INTR sample register = 0. Reset overrides every other input.
- Per-edge priority, highest first: RETI, INT_ACK, explicit set/clear, load.
- RETI: C_FLAG <= shadow C, Z_FLAG <= shadow Z, I_FLAG <= RETI_IEN.
  - When RETI is asserted, INT_ACK, FLG_*, I_SET and I_CLR are ignored that cycle.
  - The pending latch still updates from INTR.
- INT_ACK without RETI: shadow <= current {C_FLAG, Z_FLAG}, I_FLAG <= 0, pending <= 0.
  - C and Z still update from FLG_* this cycle.
  - The shadow always captures the pre-edge flag values.
- C update: FLG_C_CLR wins over FLG_C_SET, which wins over FLG_C_LD. No request held means C is unchanged.
- Z update: FLG_Z_LD loads ALU_Z; otherwise Z is unchanged.
- I update when neither RETI nor INT_ACK is asserted: I_CLR wins over I_SET.
- Flag latency: one edge. Updated flags are visible on the outputs, CIN and BR_TAKE immediately after the edge.
- Pending latch, INT_EDGE = 1:
  - The INTR sample register captures INTR every edge.
  - pending is set on any edge where INTR = 1 and the sample register = 0.
  - A new rising edge in the same cycle as INT_ACK leaves pending = 1; the new event is not lost.
  - Further edges while pending = 1 are absorbed; there is no counting.
- Pending latch, INT_EDGE = 0: pending <= INTR every edge. INT_ACK clears pending for that edge only.
- Pending is recorded while I_FLAG = 0. INT_REQ asserts as soon as I_FLAG becomes 1.
- BR_COND encoding:
  - 000: always (1)
  - 001: BRCC (!C)
  - 010: BRCS (C)
  - 011: BREQ (Z)
  - 100: BRNE (!Z)
  - 101-111: never (0)
- No internal FSM beyond these registers. The control unit sequences INT_ACK and RETI.

Test Plan:
- Reset with RST_N = 0 while FLG_C_SET = 1 and INTR = 1 -> after the edge C = 0, Z = 0, I = RESET_I, INT_REQ = 0. Verify that an RST_N = 0 pulse mid-sequence clears all state on that edge.
- ALU_C = 1, ALU_Z = 0, FLG_C_LD = FLG_Z_LD = 1 -> next cycle C_FLAG = 1, CIN = 1, Z_FLAG = 0. BR_COND = 010 gives BR_TAKE = 1; 011 gives 0; 111 gives 0.
- FLG_C_SET = FLG_C_CLR = FLG_C_LD = 1 with ALU_C = 1 -> C_FLAG = 0. Then FLG_C_SET alone -> C_FLAG = 1.
- I_SET, then an INTR 0->1 edge -> INT_REQ = 1 one cycle after the INTR sample. Hold INTR high three cycles -> pending is set once only. With I_CLR asserted, INT_REQ = 0 while pending is still held.
- With C = 1, Z = 1, pulse INT_ACK with FLG_C_CLR = 1 -> shadow = {1,1}, C = 0, I = 0, INT_REQ = 0. Then RETI with RETI_IEN = 1 -> C = 1, Z = 1, I = 1.
- INTR rising edge in the same cycle as INT_ACK -> pending = 1 after the edge. RETI and INT_ACK together -> the RETI result is taken and the shadow is unchanged.
